// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between I-cache refill (device 1) and D-cache (device 2).
// Tie priority: device 2 fixed by default; alternating when MEM_ARB_ROUND_ROBIN_EN is defined.
module mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] device_1_mem_addr,
  input  logic [ADDR_W-1:0] device_2_mem_addr,
  input  logic [31:0]       device_2_mem_di,
  input  logic [3:0]        device_2_bank_select,
  input  logic [1:0]        devices_mem_en,
  input  logic [1:0]        devices_mem_we,
  input  logic [1:0]        devices_burst_en,
  output logic [1:0]        devices_do_ack,
  output logic [31:0]       mem_do,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  localparam int CNT_W = $clog2(BURST_LEN);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              burst_q, burst_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [1:0]        ack_q, ack_d;
  logic [31:0]       do_q, do_d;
  logic              pick;
  logic              pick_we;

  // Device 1 is read-only, so its write flag never matters.
  logic unused_dev1_we;
  assign unused_dev1_we = devices_mem_we[0];

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  always_comb pick = (&devices_mem_en) ? ~last_q : devices_mem_en[1];
`else
  always_comb pick = devices_mem_en[1];
`endif

  assign pick_we        = pick & devices_mem_we[1];
  assign devices_do_ack = ack_q;
  assign mem_do         = do_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    we_d      = we_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    ack_d     = 2'b00;
    do_d      = do_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d    = last_q;
`endif
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_wdata = 32'h0;
    case (state_q)
      IDLE: begin
        beat_d = '0;
        if (|devices_mem_en) begin
          grant_d = pick;
          addr_d  = pick ? device_2_mem_addr : device_1_mem_addr;
          we_d    = pick_we;
          burst_d = devices_burst_en[pick] & ~pick_we;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_d  = pick;
`endif
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_req   = 1'b1;
        mem_addr  = addr_q + ADDR_W'(beat_q);
        mem_we    = we_q;
        mem_be    = (grant_q & we_q) ? device_2_bank_select : 4'hF;
        mem_wdata = device_2_mem_di;
        if (mem_ready) begin
          ack_d[grant_q] = 1'b1;
          if (!we_q) do_d = mem_rdata;
          if (burst_q && (beat_q != CNT_W'(BURST_LEN - 1))) beat_d = beat_q + CNT_W'(1);
          else state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      burst_q <= 1'b0;
      beat_q  <= '0;
      ack_q   <= 2'b00;
      do_q    <= 32'h0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      ack_q   <= ack_d;
      do_q    <= do_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: transaction-level model of grant order, addresses, acks and read data.
module tb_mem_arbiter;
  localparam int ADDR_W    = 16;
  localparam int BURST_LEN = 4;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] device_1_mem_addr, device_2_mem_addr;
  logic [31:0]       device_2_mem_di;
  logic [3:0]        device_2_bank_select;
  logic [1:0]        devices_mem_en, devices_mem_we, devices_burst_en, devices_do_ack;
  logic [31:0]       mem_do, mem_wdata, mem_rdata;
  logic              mem_req, mem_we, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;

  mem_arbiter #(.ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN)) dut (
    .clk(clk), .reset(reset),
    .device_1_mem_addr(device_1_mem_addr), .device_2_mem_addr(device_2_mem_addr),
    .device_2_mem_di(device_2_mem_di), .device_2_bank_select(device_2_bank_select),
    .devices_mem_en(devices_mem_en), .devices_mem_we(devices_mem_we),
    .devices_burst_en(devices_burst_en), .devices_do_ack(devices_do_ack),
    .mem_do(mem_do), .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          m_last;      // device index (0/1) granted most recently
  logic [31:0] m_last_rd;   // value mem_do must hold
  logic [15:0] p_addr [2];
  logic        p_we [2];
  logic        p_burst [2];
  logic [31:0] p_di;
  logic [3:0]  p_be;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {16'hCAFE, a};
  endfunction

  function automatic int next_wait(input int f);
    return (f >= 0) ? f : int'($urandom_range(3, 0));
  endfunction

  task automatic set_dev(input int d, input logic [15:0] a, input logic w, input logic b);
    p_addr[d]  = a;
    p_we[d]    = w;
    p_burst[d] = b;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    devices_mem_en = 2'b00;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ack", 64'(devices_do_ack), 64'd0);
    check("rst_do", 64'(mem_do), 64'd0);
    check("rst_bus", {10'd0, mem_req, mem_we, mem_be, mem_addr, mem_wdata}, 64'd0);
    reset = 1'b0;
    m_last = 1;
    m_last_rd = 32'h0;
  endtask

  task automatic idle_check(input int n);
    repeat (n) begin
      @(negedge clk);
      check("idle_req", 64'(mem_req), 64'd0);
      check("idle_ack", 64'(devices_do_ack), 64'd0);
      check("idle_do", 64'(mem_do), 64'(m_last_rd));
    end
  endtask

  // n1/n2 back-to-back transactions per device; wait_fix<0 means random memory wait states.
  // abort_after>0 pulses reset once that many acks of the first transaction were seen.
  task automatic run_traffic(input int n1, input int n2, input int wait_fix, input int abort_after);
    int rem [2];
    int seq [$];
    int r0, r1, g, t, issued, acked, waitc, txn_waits, elapsed, exp_elapsed, beats;
    bit pend, wr, fin;
    logic [31:0] pend_dat;
    logic [15:0] ea;
    logic [3:0]  eb;
    rem[0] = n1; rem[1] = n2; r0 = n1; r1 = n2;
    while (r0 + r1 > 0) begin
      if (r0 > 0 && r1 > 0) g = RR ? ((m_last == 1) ? 0 : 1) : 1;
      else g = (r0 > 0) ? 0 : 1;
      seq.push_back(g);
      m_last = g;
      if (g == 0) r0--; else r1--;
    end
    @(negedge clk);
    device_1_mem_addr    = p_addr[0];
    device_2_mem_addr    = p_addr[1];
    device_2_mem_di      = p_di;
    device_2_bank_select = p_be;
    devices_mem_we       = {p_we[1], p_we[0]};
    devices_burst_en     = {p_burst[1], p_burst[0]};
    devices_mem_en       = {rem[1] > 0, rem[0] > 0};
    t = 0; issued = 0; acked = 0; pend = 1'b0; txn_waits = 0;
    elapsed = 0; exp_elapsed = 0; fin = 1'b0; pend_dat = 32'h0;
    waitc = next_wait(wait_fix);
    while (!fin) begin
      @(negedge clk);
      elapsed++;
      g = seq[t];
      beats = (p_burst[g] && !(g == 1 && p_we[1])) ? BURST_LEN : 1;
      check("ack", 64'(devices_do_ack), pend ? (64'd1 << g) : 64'd0);
      check("mem_do", 64'(mem_do), 64'(pend ? pend_dat : m_last_rd));
      if (pend) begin
        pend = 1'b0;
        m_last_rd = pend_dat;
        acked++;
        if (abort_after > 0 && acked == abort_after) begin
          reset = 1'b1;
          mem_ready = 1'b0;
          devices_mem_en = 2'b00;
          #1;
          check("rst_mid_req", 64'(mem_req), 64'd0);
          check("rst_mid_ack", 64'(devices_do_ack), 64'd0);
          check("rst_mid_do", 64'(mem_do), 64'd0);
          @(negedge clk);
          reset = 1'b0;
          m_last = 1;
          m_last_rd = 32'h0;
          break;
        end
        if (acked == beats) begin
          exp_elapsed += beats + txn_waits + 2;
          rem[g]--;
          devices_mem_en[g] = (rem[g] > 0);
          t++; acked = 0; issued = 0; txn_waits = 0;
          if (t == seq.size()) begin
            check("latency", 64'(elapsed), 64'(exp_elapsed - 1));
            fin = 1'b1;
          end else begin
            g = seq[t];
            beats = (p_burst[g] && !(g == 1 && p_we[1])) ? BURST_LEN : 1;
          end
        end
      end
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (mem_req) begin
        if (t >= seq.size() || issued >= beats) begin
          check("extra_req", 64'(mem_req), 64'd0);
        end else begin
          wr = (g == 1) && p_we[1];
          ea = p_addr[g] + 16'(issued);
          eb = wr ? p_be : 4'hF;
          check("req_bus", {11'd0, mem_we, mem_be, mem_addr, mem_wdata}, {11'd0, wr, eb, ea, p_di});
          if (waitc > 0) begin
            waitc--;
            txn_waits++;
          end else begin
            mem_ready = 1'b1;
            mem_rdata = mem_word(mem_addr);
            pend = 1'b1;
            pend_dat = wr ? m_last_rd : mem_word(ea);
            issued++;
            waitc = next_wait(wait_fix);
          end
        end
      end else begin
        check("idle_bus", {11'd0, mem_we, mem_be, mem_addr, mem_wdata}, 64'd0);
      end
      if (elapsed > 2000) begin
        check("timeout", 64'(elapsed), 64'd0);
        fin = 1'b1;
      end
    end
    devices_mem_en = 2'b00;
    mem_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    device_1_mem_addr = '0; device_2_mem_addr = '0;
    device_2_mem_di = '0; device_2_bank_select = '0;
    devices_mem_en = '0; devices_mem_we = '0; devices_burst_en = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    m_last = 1; m_last_rd = '0;
    set_dev(0, 16'h0, 1'b0, 1'b0);
    set_dev(1, 16'h0, 1'b0, 1'b0);
    p_di = 32'h0; p_be = 4'h0;
    do_reset();

    // single read, 2 wait states
    set_dev(0, 16'h0010, 1'b0, 1'b0);
    run_traffic(1, 0, 2, 0);
    idle_check(2);
    // single write, mem_do must hold CAFE0010
    set_dev(1, 16'h0200, 1'b1, 1'b0);
    p_di = 32'h12345678; p_be = 4'b0011;
    run_traffic(0, 1, 1, 0);
    idle_check(2);
    // burst wrapping past the top of the address space
    set_dev(0, 16'hFFFE, 1'b1, 1'b1);
    run_traffic(1, 0, -1, 0);
    idle_check(2);
    // burst request with write collapses to one beat
    set_dev(1, 16'h0300, 1'b1, 1'b1);
    p_di = 32'hA5A5_0F0F; p_be = 4'b1100;
    run_traffic(0, 1, -1, 0);
    idle_check(2);
    // simultaneous requests, zero-wait memory
    do_reset();
    set_dev(0, 16'h1000, 1'b0, 1'b0);
    set_dev(1, 16'h2000, 1'b0, 1'b0);
    run_traffic(2, 3, 0, 0);
    idle_check(2);
    // reset after beat 2 of a burst, then a fresh read
    set_dev(0, 16'h4000, 1'b0, 1'b1);
    run_traffic(1, 0, -1, 2);
    idle_check(2);
    set_dev(0, 16'h4100, 1'b0, 1'b0);
    run_traffic(1, 0, -1, 0);
    idle_check(1);

    for (int i = 0; i < 25; i++) begin
      int n1, n2;
      n1 = $urandom_range(2, 0);
      n2 = $urandom_range(2, 0);
      if (n1 + n2 == 0) n1 = 1;
      set_dev(0, 16'($urandom), 1'($urandom), 1'($urandom));
      set_dev(1, 16'($urandom), 1'($urandom), 1'($urandom));
      p_di = $urandom;
      p_be = 4'($urandom);
      run_traffic(n1, n2, -1, 0);
      idle_check(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
